light_monitor: RTL
==================

LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter GREEN_LEN, default 71, required green phase length in clock cycles.
REQ-002 Parameter YELLOW_LEN, default 6, required yellow phase length in clock cycles, for both yellow phases.
REQ-003 Parameter RED_LEN, default 76, required red phase length in clock cycles.
REQ-004 Parameter TOL, default 1, allowed +/- deviation in cycles for every phase length.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 enable  input  1  monitoring enable; same meaning as the controller's enable.
REQ-008 green, yellow, red  input  1 each  lamp outputs of the traffic-light controller.
REQ-009 phase  output  3  current tracked state encoding, per REQ-012.
REQ-010 err_multi, err_seq, err_dur, err_dark  output  1 each  one-cycle error pulses.
REQ-011 err_sticky  output  1  OR of all error pulses since reset; cycle_cnt  output  16  completed legal light cycles.

Function
REQ-012 The FSM SHALL have states IDLE=0, GREEN=1, Y_AG=2 (yellow after green), RED=3, Y_AR=4 (yellow after red), SYNC=5.
REQ-013 Every input SHALL be sampled on the rising clk edge; all outputs SHALL be registered; errors SHALL appear in the cycle following the edge that sampled the offending inputs.
REQ-014 lamp = {green, yellow, red}; "single" SHALL mean exactly one bit is set; "dark" SHALL mean lamp == 0.
REQ-015 An 8-bit duration counter SHALL count the sampled cycles of the current lamp, saturating at 255; it SHALL load 1 on every lamp change.
REQ-016 enable = 0 SHALL force IDLE, clear the duration counter, and produce no error; cycle_cnt and err_sticky SHALL hold.
REQ-017 IDLE: on a single green, go to GREEN; on any other non-dark single lamp, go to SYNC with no error.
REQ-018 Legal transitions SHALL be GREEN->Y_AG, Y_AG->RED, RED->Y_AR, and Y_AR->GREEN, each taken when the sampled single lamp changes to the next colour.
REQ-019 On each legal transition, the finished phase length SHALL be checked against [LEN-TOL, LEN+TOL]; if outside that range, err_dur SHALL pulse and the FSM SHALL take the legal transition anyway.
REQ-020 Any other single-lamp change from a tracked state (e.g. GREEN->red, Y_AG->green) SHALL pulse err_seq and the FSM SHALL go to SYNC.
REQ-021 In GREEN, RED, or a yellow state, a lamp staying unchanged beyond LEN+TOL cycles SHALL pulse err_dur once, at count LEN+TOL+1, with no state change.
REQ-022 A multi-lamp sample (two or more lamp bits set) SHALL pulse err_multi every such cycle; the state and duration counter SHALL hold; no other error SHALL be raised in that cycle.
REQ-023 A dark sample with enable = 1 in any state other than IDLE and SYNC SHALL pulse err_dark and go to SYNC.
REQ-024 SYNC: wait for a single green, enter GREEN, and perform no duration check on that green phase's predecessor.
REQ-025 cycle_cnt SHALL increment on every legal Y_AR->GREEN transition, regardless of err_dur, and SHALL wrap from 0xFFFF to 0.
REQ-026 err_sticky SHALL set in the same cycle as any error pulse and clear only on rst.
REQ-027 Simultaneous enable fall and a lamp change SHALL resolve to REQ-016 (enable has priority).

Reset
REQ-028 With rst = 1 at an edge: phase = IDLE, duration counter = 0, all err_* = 0, err_sticky = 0, cycle_cnt = 0.
REQ-029 rst mid-phase SHALL abandon the phase with no error; after rst is released, tracking SHALL restart per REQ-017.
REQ-030 rst SHALL have priority over enable and all lamp inputs.

Verification
REQ-031 enable = 1; green 71, yellow 6, red 76, yellow 6, green cycles -> no errors, cycle_cnt = 1, phase sequence 1,2,3,4,1.
REQ-032 green held 80 cycles -> err_dur pulses once, at count 73; on yellow, a second err_dur pulse occurs; phase = 2.
REQ-033 green 71 then red directly -> err_seq pulse, phase = 5; later green -> phase = 1, err_sticky = 1.
REQ-034 green and red both high for 3 cycles during GREEN -> err_multi high 3 cycles, phase stays 1, duration resumes counting afterwards.
REQ-035 all lamps low 1 cycle in RED -> err_dark pulse, phase = 5; rst pulse -> all outputs zero, phase = 0.
REQ-036 cycle_cnt preloaded to 0xFFFF via 65535 legal cycles (or forced) plus one more legal cycle -> cycle_cnt = 0x0000.

Source files
------------

// File: rtl/light_monitor.sv
// Traffic-light lamp monitor: tracks the G -> Y -> R -> Y cycle, checks phase
// lengths and lamp legality, and flags errors as one-cycle registered pulses.
module light_monitor #(
  parameter int GREEN_LEN  = 71,
  parameter int YELLOW_LEN = 6,
  parameter int RED_LEN    = 76,
  parameter int TOL        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        green,
  input  logic        yellow,
  input  logic        red,
  output logic [2:0]  phase,
  output logic        err_multi,
  output logic        err_seq,
  output logic        err_dur,
  output logic        err_dark,
  output logic        err_sticky,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GREEN = 3'd1,
    Y_AG = 3'd2,
    RED = 3'd3,
    Y_AR = 3'd4,
    SYNC = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  state_t      state, state_n, succ;
  logic [7:0]  dur, dur_n;
  logic [2:0]  last, last_n;
  logic [15:0] cnt_n;
  logic        multi_n, seq_n, dur_err_n, dark_n;
  logic [2:0]  lamp, own_colour, next_colour;
  logic        single, dark, tracked;
  int          len;

  assign lamp    = {green, yellow, red};
  assign single  = $onehot(lamp);
  assign dark    = (lamp == '0);
  assign tracked = (own_colour != '0);
  assign phase   = state;

  // Per-state lamp colour, expected successor colour and nominal length.
  always_comb begin
    own_colour  = '0;
    next_colour = '0;
    succ        = SYNC;
    len         = 0;
    case (state)
      GREEN: begin own_colour = LAMP_G; next_colour = LAMP_Y; succ = Y_AG;  len = GREEN_LEN;  end
      Y_AG:  begin own_colour = LAMP_Y; next_colour = LAMP_R; succ = RED;   len = YELLOW_LEN; end
      RED:   begin own_colour = LAMP_R; next_colour = LAMP_Y; succ = Y_AR;  len = RED_LEN;    end
      Y_AR:  begin own_colour = LAMP_Y; next_colour = LAMP_G; succ = GREEN; len = YELLOW_LEN; end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    dur_n     = dur;
    last_n    = last;
    cnt_n     = cycle_cnt;
    multi_n   = 1'b0;
    seq_n     = 1'b0;
    dur_err_n = 1'b0;
    dark_n    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      dur_n   = '0;
      last_n  = '0;
    end else if (!single && !dark) begin
      // Multi-lamp sample freezes tracking so the phase resumes afterwards.
      multi_n = 1'b1;
    end else begin
      last_n = lamp;
      if (lamp != last)      dur_n = 8'd1;
      else if (dur != '1)    dur_n = dur + 8'd1;
      if (!tracked) begin
        if (lamp == LAMP_G)               state_n = GREEN;
        else if (state == IDLE && !dark)  state_n = SYNC;
      end else if (dark) begin
        dark_n  = 1'b1;
        state_n = SYNC;
      end else if (lamp == next_colour) begin
        dur_err_n = (int'(dur) < len - TOL) || (int'(dur) > len + TOL);
        if (state == Y_AR) cnt_n = cycle_cnt + 16'd1;
        state_n = succ;
      end else if (lamp != own_colour) begin
        seq_n   = 1'b1;
        state_n = SYNC;
      end else if (dur != '1 && int'(dur) == len + TOL) begin
        dur_err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dur        <= '0;
      last       <= '0;
      err_multi  <= 1'b0;
      err_seq    <= 1'b0;
      err_dur    <= 1'b0;
      err_dark   <= 1'b0;
      err_sticky <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_n;
      dur        <= dur_n;
      last       <= last_n;
      err_multi  <= multi_n;
      err_seq    <= seq_n;
      err_dur    <= dur_err_n;
      err_dark   <= dark_n;
      err_sticky <= err_sticky | multi_n | seq_n | dur_err_n | dark_n;
      cycle_cnt  <= cnt_n;
    end
  end

endmodule
